// File: rtl/lock_rr_arb.sv
// Round-robin lock arbiter: a requester keeps the lock while it holds its request.
// Optional hold-limit revocation is built when ARB_HOLD_TIMEOUT_EN is defined.
module lock_rr_arb #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         reqs_in,
  output logic [N_REQ-1:0]         gnt_out,
  output logic [$clog2(N_REQ)-1:0] gnt_idx_out,
  output logic                     gnt_valid_out,
  output logic                     timeout_out
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 32 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_param
    $error("lock_rr_arb: N_REQ or MAX_HOLD out of range");
  end

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          owner_req;

  // First set request at or above rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    int c;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_idx   = '0;
    pick_found = 1'b0;
    c          = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(rr_ptr) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!pick_found && reqs_in[IW'(c)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  assign owner_req = reqs_in[gnt_idx_out];

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
`else
  assign timeout_out = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FREE;
      rr_ptr        <= '0;
      gnt_out       <= '0;
      gnt_idx_out   <= '0;
      gnt_valid_out <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt      <= '0;
      timeout_out   <= 1'b0;
`endif
    end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
      timeout_out <= 1'b0;
`endif
      unique case (state)
        FREE: begin
          if (pick_found) begin
            state         <= LOCKED;
            gnt_out       <= N_REQ'(1) << pick_idx;
            gnt_idx_out   <= pick_idx;
            gnt_valid_out <= 1'b1;
            rr_ptr        <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt      <= HW'(1);
`endif
          end
        end
        LOCKED: begin
          // A voluntary release wins over a limit reached in the same cycle.
          if (!owner_req) begin
            state         <= FREE;
            gnt_out       <= '0;
            gnt_valid_out <= 1'b0;
          end
`ifdef ARB_HOLD_TIMEOUT_EN
          else if (hold_cnt == HW'(MAX_HOLD)) begin
            state         <= FREE;
            gnt_out       <= '0;
            gnt_valid_out <= 1'b0;
            timeout_out   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
`endif
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_rr_arb.sv
// Directed self-checking bench for lock_rr_arb (N_REQ=4, MAX_HOLD=4).
// Checks the hold-limit path when ARB_HOLD_TIMEOUT_EN is defined, indefinite hold otherwise.
module tb_lock_rr_arb;

  logic       clock;
  logic       reset_n;
  logic [3:0] reqs;
  logic [3:0] gnt;
  logic [1:0] idx;
  logic       valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  lock_rr_arb #(.N_REQ(4), .MAX_HOLD(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .reqs_in       (reqs),
    .gnt_out       (gnt),
    .gnt_idx_out   (idx),
    .gnt_valid_out (valid),
    .timeout_out   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against one expected state; valid must track gnt.
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                         input logic t);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".idx"}, 32'(idx), 32'(i));
    check({tag, ".valid"}, 32'(valid), 32'(|g));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    reqs    = 4'b0000;
    tick();
    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    reset_n = 1'b1;

    // No requests: nothing moves.
    tick();
    tick();
    chk_out("idle", 4'b0000, 2'd0, 1'b0);

    // First grant goes to lowest set index at or above 0.
    reqs = 4'b1010;
    tick();
    chk_out("first_grant", 4'b0010, 2'd1, 1'b0);

    // Non-owner request changes have no effect.
    reqs = 4'b1110;
    tick();
    chk_out("nonowner_a", 4'b0010, 2'd1, 1'b0);
    reqs = 4'b1011;
    tick();
    chk_out("nonowner_b", 4'b0010, 2'd1, 1'b0);

    // Owner 1 drops with 3 waiting: one dead cycle, then 3.
    reqs = 4'b1000;
    tick();
    chk_out("dead_cycle", 4'b0000, 2'd1, 1'b0);
    tick();
    chk_out("grant_3", 4'b1000, 2'd3, 1'b0);

    // Release: index holds last owner while free.
    reqs = 4'b0000;
    tick();
    chk_out("release_3", 4'b0000, 2'd3, 1'b0);
    tick();
    chk_out("free_hold", 4'b0000, 2'd3, 1'b0);

    // All request, each owner holds 2 cycles then releases and re-requests.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e;
      logic [3:0] g;
      e = 2'(k % 4);
      g = 4'b0001 << e;
      reqs = 4'b1111;
      tick();
      chk_out($sformatf("rr%0d_c1", k), g, e, 1'b0);
      tick();
      chk_out($sformatf("rr%0d_c2", k), g, e, 1'b0);
      reqs = 4'b1111 & ~g;
      tick();
      chk_out($sformatf("rr%0d_dead", k), 4'b0000, e, 1'b0);
    end
    reqs = 4'b0000;
    tick();

    // Pointer now 1: 0101 grants 2, then pointer 3 wraps to 0.
    reqs = 4'b0101;
    tick();
    chk_out("ptr1_pick2", 4'b0100, 2'd2, 1'b0);
    reqs = 4'b0001;
    tick();
    chk_out("ptr1_rel2", 4'b0000, 2'd2, 1'b0);
    reqs = 4'b0101;
    tick();
    chk_out("wrap_pick0", 4'b0001, 2'd0, 1'b0);
    reqs = 4'b0000;
    tick();

    // Lock owner 2, then pulse reset mid-cycle: outputs clear before any edge.
    reqs = 4'b0100;
    tick();
    chk_out("lock_2", 4'b0100, 2'd2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;
    // Pointer reset to 0 picks 2 here; a stale pointer of 3 would pick 3.
    reqs = 4'b1100;
    tick();
    chk_out("post_reset", 4'b0100, 2'd2, 1'b0);
    reqs = 4'b0000;
    tick();
    chk_out("post_reset_rel", 4'b0000, 2'd2, 1'b0);

    // Pointer 3 with 0011 -> owner 0.
    reqs = 4'b0011;
    tick();
    chk_out("hold0_c1", 4'b0001, 2'd0, 1'b0);
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_out($sformatf("hold0_c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk_out("revoke0", 4'b0000, 2'd0, 1'b1);
    tick();
    chk_out("regrant1", 4'b0010, 2'd1, 1'b0);
    // Owner 1 releases exactly at the limit: release, no timeout.
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_out($sformatf("hold1_c%0d", c), 4'b0010, 2'd1, 1'b0);
    end
    reqs = 4'b0001;
    tick();
    chk_out("rel_at_limit", 4'b0000, 2'd1, 1'b0);
    tick();
    chk_out("grant0_again", 4'b0001, 2'd0, 1'b0);
    // Sole requester revoked is re-granted after the dead cycle.
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_out($sformatf("solo_c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk_out("solo_revoke", 4'b0000, 2'd0, 1'b1);
    tick();
    chk_out("solo_regrant", 4'b0001, 2'd0, 1'b0);
`else
    for (int c = 2; c <= 100; c++) begin
      tick();
      check($sformatf("hold0_c%0d", c), {27'd0, timeout, gnt}, {27'd0, 1'b0, 4'b0001});
    end
    chk_out("hold0_end", 4'b0001, 2'd0, 1'b0);
`endif
    reqs = 4'b0000;
    tick();
    chk_out("final_rel", 4'b0000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
